// File: rtl/fetch_pkg.sv
// Opcode encoding and inline-operand length lookup shared by fetch and exec.
package FS1;

    typedef enum logic [7:0] {
        _NOP    = 8'h00,
        _DOLIT  = 8'h01,
        _DONEXT = 8'h02,
        _ZBRAN  = 8'h03,
        _BRANCH = 8'h04,
        _DUP    = 8'h05,
        _DROP   = 8'h06,
        _ADD    = 8'h07
    } opcode_e;

    localparam logic [2:0] LEN_NONE   = 3'd0;
    localparam logic [2:0] LEN_LIT    = 3'd4;
    localparam logic [2:0] LEN_TARGET = 3'd2;

    // Undefined codes carry no operand so fetch never stalls on garbage.
    function automatic logic [2:0] opnd_len(input logic [7:0] code);
        case (code)
            _DOLIT:                   return LEN_LIT;
            _BRANCH, _ZBRAN, _DONEXT: return LEN_TARGET;
            default:                  return LEN_NONE;
        endcase
    endfunction

endpackage

// File: rtl/fetch.sv
// Byte-serial opcode fetch with inline operand assembly for the exec stage.
// Build macro FETCH_BIG_ENDIAN_EN switches operand assembly to big-endian.
module fetch
    import FS1::*;
#(
    parameter int DSZ = 32,
    parameter int ASZ = 17
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           en,
    input  logic           jmp,
    input  logic [ASZ-1:0] jmp_addr,
    output logic           mem_rd,
    output logic [ASZ-1:0] mem_addr,
    input  logic [7:0]     mem_rdata,
    output logic [7:0]     op,
    output logic [DSZ-1:0] lit,
    output logic [ASZ-1:0] op_ip,
    output logic           op_vld,
    input  logic           op_rdy
);

    typedef enum logic [1:0] {IDLE, FETCH, CAPT, VALID} state_e;

    state_e         state_q, state_d;
    logic [ASZ-1:0] ip_q, ip_d;
    logic [2:0]     need_q, need_d;
    logic [7:0]     op_q, op_d;
    logic [DSZ-1:0] lit_q, lit_d;
    logic [ASZ-1:0] op_ip_q, op_ip_d;
    logic           mem_rd_q, mem_rd_d;
    logic [ASZ-1:0] mem_addr_q, mem_addr_d;
    logic           op_vld_q, op_vld_d;
    logic [DSZ-1:0] lit_merged;

`ifdef FETCH_BIG_ENDIAN_EN
    always_comb lit_merged = {lit_q[DSZ-9:0], mem_rdata};
`else
    logic [2:0] byte_idx;
    // Operand bytes already taken = full length minus bytes still needed.
    always_comb begin
        byte_idx   = opnd_len(op_q) - need_q;
        lit_merged = lit_q | (DSZ'(mem_rdata) << {byte_idx, 3'b000});
    end
`endif

    always_comb begin
        state_d = state_q;
        ip_d    = ip_q;
        need_d  = need_q;
        op_d    = op_q;
        lit_d   = lit_q;
        op_ip_d = op_ip_q;
        case (state_q)
            IDLE:  if (en) state_d = FETCH;
            FETCH: begin
                ip_d    = ip_q + 1'b1;
                state_d = CAPT;
            end
            CAPT: begin
                if (need_q == 3'd0) begin
                    op_d    = mem_rdata;
                    op_ip_d = ip_q - 1'b1;
                    lit_d   = '0;
                    need_d  = opnd_len(mem_rdata);
                    state_d = (opnd_len(mem_rdata) == 3'd0) ? VALID : FETCH;
                end else begin
                    lit_d   = lit_merged;
                    need_d  = need_q - 1'b1;
                    state_d = (need_q == 3'd1) ? VALID : FETCH;
                end
            end
            VALID: if (op_rdy) state_d = en ? FETCH : IDLE;
            default: state_d = IDLE;
        endcase
        // Redirect overrides everything; a pending read's data is simply never captured.
        if (jmp) begin
            ip_d    = jmp_addr;
            need_d  = 3'd0;
            state_d = en ? FETCH : IDLE;
        end
        mem_rd_d   = (state_d == FETCH);
        mem_addr_d = (state_d == FETCH) ? ip_d : mem_addr_q;
        op_vld_d   = (state_d == VALID);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            ip_q       <= '0;
            need_q     <= '0;
            op_q       <= _NOP;
            lit_q      <= '0;
            op_ip_q    <= '0;
            mem_rd_q   <= 1'b0;
            mem_addr_q <= '0;
            op_vld_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            ip_q       <= ip_d;
            need_q     <= need_d;
            op_q       <= op_d;
            lit_q      <= lit_d;
            op_ip_q    <= op_ip_d;
            mem_rd_q   <= mem_rd_d;
            mem_addr_q <= mem_addr_d;
            op_vld_q   <= op_vld_d;
        end
    end

    assign mem_rd   = mem_rd_q;
    assign mem_addr = mem_addr_q;
    assign op       = op_q;
    assign lit      = lit_q;
    assign op_ip    = op_ip_q;
    assign op_vld   = op_vld_q;

endmodule

// File: tb/tb_fetch.sv
// Directed-vector bench for fetch: byte memory model plus hand-computed expectations.
module tb_fetch;
    import FS1::*;

    localparam int DSZ = 32;
    localparam int ASZ = 17;

    logic           clk = 1'b0;
    logic           rst;
    logic           en;
    logic           jmp;
    logic [ASZ-1:0] jmp_addr;
    logic           mem_rd;
    logic [ASZ-1:0] mem_addr;
    logic [7:0]     mem_rdata;
    logic [7:0]     op;
    logic [DSZ-1:0] lit;
    logic [ASZ-1:0] op_ip;
    logic           op_vld;
    logic           op_rdy;

    logic [7:0] mem [0:(1<<ASZ)-1];
    int nvec = 0;
    int nerr = 0;

    fetch #(.DSZ(DSZ), .ASZ(ASZ)) dut (
        .clk(clk), .rst(rst), .en(en), .jmp(jmp), .jmp_addr(jmp_addr),
        .mem_rd(mem_rd), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
        .op(op), .lit(lit), .op_ip(op_ip), .op_vld(op_vld), .op_rdy(op_rdy)
    );

    always #5 clk = ~clk;

    // Synchronous byte memory: data one cycle after the strobe.
    always @(posedge clk) begin
        if (mem_rd) mem_rdata <= mem[mem_addr];
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset_outs(input string tag);
        chk({tag, ".op_vld"}, 64'(op_vld), 64'd0);
        chk({tag, ".mem_rd"}, 64'(mem_rd), 64'd0);
        chk({tag, ".mem_addr"}, 64'(mem_addr), 64'd0);
        chk({tag, ".op"}, 64'(op), 64'(_NOP));
        chk({tag, ".lit"}, 64'(lit), 64'd0);
        chk({tag, ".op_ip"}, 64'(op_ip), 64'd0);
    endtask

    logic [DSZ-1:0] lit_exp;

    initial begin
        for (int i = 0; i < (1 << ASZ); i++) mem[i] = _NOP;
        mem[17'h00000] = _DUP;
        mem[17'h00010] = _DOLIT;
        mem[17'h00011] = 8'h78;
        mem[17'h00012] = 8'h56;
        mem[17'h00013] = 8'h34;
        mem[17'h00014] = 8'h12;
        mem[17'h00015] = _BRANCH;
        mem[17'h00016] = 8'h34;
        mem[17'h00017] = 8'h12;
        mem[17'h00020] = _DUP;
        mem[17'h1FFFF] = _DUP;
`ifdef FETCH_BIG_ENDIAN_EN
        lit_exp = 32'h78563412;
`else
        lit_exp = 32'h12345678;
`endif
        mem_rdata = 8'h00;
        rst = 1'b0; en = 1'b0; jmp = 1'b0; jmp_addr = '0; op_rdy = 1'b0;

        tick(); tick();
        chk_reset_outs("reset");

        // Release with en: FETCH at cycle 1, op_vld at cycle 3.
        rst = 1'b1; en = 1'b1;
        tick();
        chk("dup.fetch_rd", 64'(mem_rd), 64'd1);
        chk("dup.fetch_addr", 64'(mem_addr), 64'd0);
        tick();
        chk("dup.capt_rd", 64'(mem_rd), 64'd0);
        chk("dup.capt_vld", 64'(op_vld), 64'd0);
        tick();
        chk("dup.vld", 64'(op_vld), 64'd1);
        chk("dup.op", 64'(op), 64'(_DUP));
        chk("dup.op_ip", 64'(op_ip), 64'd0);
        chk("dup.lit", 64'(lit), 64'd0);

        // Back-pressure: hold for 5 cycles.
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("stall.vld", 64'(op_vld), 64'd1);
            chk("stall.op", 64'(op), 64'(_DUP));
            chk("stall.rd", 64'(mem_rd), 64'd0);
        end
        op_rdy = 1'b1;
        tick();
        op_rdy = 1'b0;
        chk("hs.rd", 64'(mem_rd), 64'd1);
        chk("hs.addr", 64'(mem_addr), 64'd1);
        chk("hs.vld", 64'(op_vld), 64'd0);

        // Jump to _DOLIT while a read of 0x001 is in flight.
        jmp = 1'b1; jmp_addr = 17'h00010;
        tick();
        jmp = 1'b0;
        chk("lit.fetch_rd", 64'(mem_rd), 64'd1);
        chk("lit.fetch_addr", 64'(mem_addr), 64'h10);
        for (int i = 1; i <= 10; i++) begin
            tick();
            if (i < 10) begin
                chk("lit.busy_vld", 64'(op_vld), 64'd0);
                chk("lit.rd", 64'(mem_rd), 64'((i % 2) == 0));
                if ((i % 2) == 0) chk("lit.addr", 64'(mem_addr), 64'(17'h10 + i / 2));
            end
        end
        chk("lit.vld", 64'(op_vld), 64'd1);
        chk("lit.op", 64'(op), 64'(_DOLIT));
        chk("lit.op_ip", 64'(op_ip), 64'h10);
        chk("lit.lit", 64'(lit), 64'(lit_exp));

        op_rdy = 1'b1;
        tick();
        op_rdy = 1'b0;
        chk("br.fetch_addr", 64'(mem_addr), 64'h15);
        // _BRANCH: t1 CAPT, t2 FETCH, t3 CAPT, t4 FETCH, t5 CAPT of 2nd operand byte.
        for (int i = 1; i <= 4; i++) tick();
        jmp = 1'b1; jmp_addr = 17'h00020;
        tick();
        jmp = 1'b0;
        chk("br.flush_vld", 64'(op_vld), 64'd0);
        chk("br.flush_addr", 64'(mem_addr), 64'h20);
        tick();
        chk("br.capt_vld", 64'(op_vld), 64'd0);
        tick();
        chk("br.next_vld", 64'(op_vld), 64'd1);
        chk("br.next_op", 64'(op), 64'(_DUP));
        chk("br.next_op_ip", 64'(op_ip), 64'h20);

        // Jump coincident with handshake, to the top of memory.
        op_rdy = 1'b1; jmp = 1'b1; jmp_addr = 17'h1FFFF;
        tick();
        op_rdy = 1'b0; jmp = 1'b0;
        chk("top.vld", 64'(op_vld), 64'd0);
        chk("top.addr", 64'(mem_addr), 64'h1FFFF);
        tick(); tick();
        chk("top.op_vld", 64'(op_vld), 64'd1);
        chk("top.op_ip", 64'(op_ip), 64'h1FFFF);
        op_rdy = 1'b1;
        tick();
        op_rdy = 1'b0;
        chk("wrap.rd", 64'(mem_rd), 64'd1);
        chk("wrap.addr", 64'(mem_addr), 64'd0);

        // en dropped mid-fetch: opcode still completes, then IDLE.
        en = 1'b0;
        tick(); tick();
        chk("stop.vld", 64'(op_vld), 64'd1);
        chk("stop.op_ip", 64'(op_ip), 64'd0);
        op_rdy = 1'b1;
        tick();
        op_rdy = 1'b0;
        chk("stop.idle_vld", 64'(op_vld), 64'd0);
        chk("stop.idle_rd", 64'(mem_rd), 64'd0);
        tick();
        chk("stop.idle_rd2", 64'(mem_rd), 64'd0);

        // Jump from IDLE into _DOLIT, then reset part way through the operand.
        en = 1'b1; jmp = 1'b1; jmp_addr = 17'h00010;
        tick();
        jmp = 1'b0;
        chk("rst2.fetch_addr", 64'(mem_addr), 64'h10);
        for (int i = 0; i < 4; i++) tick();
        chk("rst2.pre_op", 64'(op), 64'(_DOLIT));
        #2;
        rst = 1'b0;
        #1;
        chk_reset_outs("rst2");
        en = 1'b0;
        tick();
        rst = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            chk("rst2.no_vld", 64'(op_vld), 64'd0);
            chk("rst2.no_rd", 64'(mem_rd), 64'd0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/fetch.md
FETCH -- requirements
Module: fetch

Interface
REQ-001 Parameter DSZ, 32, data/operand path width in bits.
REQ-002 Parameter ASZ, 17, byte address width of opcode memory.
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 rst  input  1  asynchronous, active-low reset.
REQ-005 en  input  1  run enable; 0 stops fetching after the in-progress opcode is handed off.
REQ-006 jmp  input  1  load IP from jmp_addr and flush; one-cycle pulse from exec.
REQ-007 jmp_addr  input  ASZ  new instruction pointer.
REQ-008 mem_rd  output  1  memory read strobe.
REQ-009 mem_addr  output  ASZ  memory byte address.
REQ-010 mem_rdata  input  8  read data, valid exactly one cycle after mem_rd.
REQ-011 op  output  8  opcode (opcode_e) presented to exec.
REQ-012 lit  output  DSZ  assembled inline operand, zero-extended.
REQ-013 op_ip  output  ASZ  byte address of the presented opcode.
REQ-014 op_vld  output  1  op/lit/op_ip valid.
REQ-015 op_rdy  input  1  exec accepts; transfer when op_vld & op_rdy.

Function
REQ-016 FSM states: IDLE, FETCH, CAPT, VALID.
REQ-017 IDLE: outputs quiescent; en=1 -> FETCH next cycle.
REQ-018 FETCH: mem_rd=1, mem_addr=ip, ip<=ip+1 (wraps 2^ASZ-1 -> 0); -> CAPT.
REQ-019 CAPT on the opcode byte: op<=mem_rdata, op_ip<=ip-1, lit<=0, need<=opnd_len(mem_rdata); need=0 -> VALID, else -> FETCH.
REQ-020 CAPT on an operand byte: byte merged into lit per REQ-033; need decrements; need reaching 0 -> VALID, else -> FETCH.
REQ-021 Operand lengths: _DOLIT 4 bytes; _BRANCH, _ZBRAN, _DONEXT 2 bytes (zero-extended); all others, including undefined codes, 0 bytes.
REQ-022 Latency: a 0-operand opcode asserts op_vld 2 cycles after its FETCH cycle; an n-byte operand adds 2n cycles.
REQ-023 VALID: op_vld=1; op, lit and op_ip are held stable until op_rdy.
REQ-024 On handshake in VALID: en=1 -> FETCH; en=0 -> IDLE.
REQ-025 en deasserted in FETCH/CAPT: the current opcode and operand complete and are handed off before entering IDLE.
REQ-026 jmp, any state: ip<=jmp_addr, need<=0, op_vld<=0 next cycle, in-flight read data discarded; -> FETCH if en, else IDLE.
REQ-027 jmp coincident with a handshake: the transfer counts as accepted, and jmp still flushes.
REQ-028 mem_rd is never asserted outside FETCH, and at most one read is outstanding.

Reset
REQ-029 rst low asynchronously forces state IDLE, ip=0, need=0, op=_NOP, lit=0, op_ip=0, op_vld=0, mem_rd=0, mem_addr=0.
REQ-030 Release of rst takes effect at the first rising clk edge with rst high; IDLE until en.
REQ-031 rst asserted mid-operand: the partial operand is lost, and no op_vld is produced for it.

Configuration
REQ-032 Macro FETCH_BIG_ENDIAN_EN selects operand byte order.
REQ-033 Undefined (default): little-endian, operand byte k goes to lit[8k+7:8k]. Defined: big-endian, lit<={lit[DSZ-9:0], byte}.

Structure
REQ-034 opcode_e, the opnd_len() function and the operand-length constants live in package FS1; the FSM state enum is local to the module.
REQ-035 Single module, no sub-modules; the exec stage consumes op, lit and op_vld directly.

Verification
REQ-036 Memory holds _DUP at 0x000; reset, then en=1 -> FETCH at cycle 1, op_vld at cycle 3, op=_DUP, op_ip=0, lit=0.
REQ-037 _DOLIT, 0x78, 0x56, 0x34, 0x12 at 0x010, via jmp to 0x010 -> op_vld 10 cycles after first FETCH, lit=0x12345678 (0x78563412 with FETCH_BIG_ENDIAN_EN).
REQ-038 op_rdy held 0 for 5 cycles in VALID -> outputs stable and no mem_rd; op_rdy=1 -> next FETCH on the following cycle.
REQ-039 jmp to 0x020 during the 2nd operand byte of _BRANCH -> no op_vld for _BRANCH; next op_ip=0x020.
REQ-040 jmp to 0x1FFFF with a 0-operand opcode there -> next FETCH at 0x00000 (wrap). rst low mid-_DOLIT -> all outputs at reset values immediately.
